f5_weight_streamer: RTL and testbench

Source-side sequencer for the F5 fully-connected weight load path. It accepts packed weight words from an upstream valid/ready word stream (DMA or host FIFO), unpacks each word into WD-bit bytes LSB-first, and drives `f5_weight_data`/`f5_weight_en` into the F5 weight buffer. It stops after exactly NW*NUM bytes, so the buffer's neuron/address counters end aligned at neuron 1, address 0.

---
 rtl/f5_weight_streamer.sv | 126 ++++++++++++
 tb/tb_f5_weight_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f5_weight_streamer.sv
// Streams packed upstream words to the F5 weight buffer one WD-bit lane per cycle, LSB lane first.
// Optional F5_WSTREAM_CKSUM_EN adds o_cksum, a 16-bit running sum of emitted bytes.
module f5_weight_streamer #(
  parameter int WD  = 8,
  parameter int NW  = 256,
  parameter int NUM = 120,
  parameter int IW  = 32
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [IW-1:0] i_s_data,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  output logic [WD-1:0] f5_weight_data,
  output logic          f5_weight_en,
  output logic          o_busy,
  output logic          o_done
`ifdef F5_WSTREAM_CKSUM_EN
  ,
  output logic [15:0]   o_cksum
`endif
);

  localparam int L     = IW / WD;
  localparam int LW    = (L > 1) ? $clog2(L) : 1;
  localparam int TOTAL = NW * NUM;
  localparam int CBW   = $clog2(TOTAL + 1);

  // IDLE wait start | FETCH need first word | SHIFT emit one lane | DONE one-cycle pulse
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_shreg;
  logic [LW-1:0]   r_cnt_l;
  logic [CBW-1:0]  r_cnt_b;
  logic            w_ready;
  logic            w_load;
  logic            w_shift;
  logic            w_clr;
  logic            w_last_byte;
  logic            w_last_lane;

  assign w_last_byte = (r_cnt_b == CBW'(TOTAL - 1));
  assign w_last_lane = (r_cnt_l == LW'(L - 1));

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_ready = 1'b1;
        if (i_s_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        // Final byte wins over prefetch so no word beyond the load is ever taken.
        if (w_last_byte) begin
          w_state_nxt = ST_DONE;
        end else if (w_last_lane) begin
          w_ready = 1'b1;
          if (i_s_valid) w_load = 1'b1;
          else           w_state_nxt = ST_FETCH;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      r_shreg <= '0;
      r_cnt_l <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_clr)        r_cnt_b <= '0;
      else if (w_shift) r_cnt_b <= r_cnt_b + CBW'(1);

      if (w_load) begin
        r_shreg <= i_s_data;
        r_cnt_l <= '0;
      end else if (w_shift) begin
        r_shreg <= r_shreg >> WD;
        r_cnt_l <= r_cnt_l + LW'(1);
      end
    end
  end

  assign o_s_ready      = w_ready;
  assign f5_weight_en   = (r_state == ST_SHIFT);
  assign f5_weight_data = f5_weight_en ? r_shreg[WD-1:0] : '0;
  assign o_busy         = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
  assign o_done         = (r_state == ST_DONE);

`ifdef F5_WSTREAM_CKSUM_EN
  logic [15:0] r_cksum;

  always_ff @(posedge i_sclk) begin
    if (!i_rstn)           r_cksum <= '0;
    else if (w_clr)        r_cksum <= '0;
    else if (f5_weight_en) r_cksum <= r_cksum + 16'(f5_weight_data);
  end

  assign o_cksum = r_cksum;
`endif

endmodule

// File: tb/tb_f5_weight_streamer.sv
// Directed bench for f5_weight_streamer: a default-size instance and a NW=3/NUM=2 instance.
module tb_f5_weight_streamer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, valid;
  logic [31:0] sdata;
  logic        ready, wen, busy, done;
  logic [7:0]  wdata;
  logic        s_start, s_valid;
  logic [31:0] s_sdata;
  logic        s_ready, s_wen, s_busy, s_done;
  logic [7:0]  s_wdata;
`ifdef F5_WSTREAM_CKSUM_EN
  logic [15:0] cksum, s_cksum;
`endif

  int total = 0;
  int bad   = 0;

  // statistics from run_load / run_small
  int en_cnt, words, first_en, last_en, done_cnt, done_cyc, err_cnt, err_act, err_exp;
  int timeout, aborted, busy_fetch, busy_done, ready_last, done_after, ready_after;
  int post_en, post_busy, post_ready;
  logic [15:0] ck_at_done;
  logic [7:0]  s_bytes [8];

  always #5 clk = ~clk;

  f5_weight_streamer dut (
    .i_sclk(clk), .i_rstn(rstn), .i_start(start), .i_s_data(sdata), .i_s_valid(valid),
    .o_s_ready(ready), .f5_weight_data(wdata), .f5_weight_en(wen), .o_busy(busy), .o_done(done)
`ifdef F5_WSTREAM_CKSUM_EN
    , .o_cksum(cksum)
`endif
  );

  f5_weight_streamer #(.NW(3), .NUM(2)) dut_s (
    .i_sclk(clk), .i_rstn(rstn), .i_start(s_start), .i_s_data(s_sdata), .i_s_valid(s_valid),
    .o_s_ready(s_ready), .f5_weight_data(s_wdata), .f5_weight_en(s_wen), .o_busy(s_busy), .o_done(s_done)
`ifdef F5_WSTREAM_CKSUM_EN
    , .o_cksum(s_cksum)
`endif
  );

  function automatic logic [31:0] mk_word(input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(4*w + k + 1);
    return r;
  endfunction

  // Drives one load on the big instance; stall_n idle cycles at the first boundary after word 2,
  // start re-pulsed at cycle start_at, synchronous reset once abort_at bytes have been seen.
  task automatic run_load(input int stall_n, input int start_at, input int abort_at);
    int cyc, bidx, stall_left;
    bit fin;
    en_cnt = 0; words = 0; first_en = -1; last_en = -1; done_cnt = 0; done_cyc = -1;
    err_cnt = 0; err_act = 0; err_exp = 0; timeout = 0; aborted = 0; busy_fetch = 0;
    busy_done = 1; ready_last = 1; done_after = 1; ready_after = 1; ck_at_done = '0;
    post_en = 1; post_busy = 1; post_ready = 1;
    cyc = 0; bidx = 0; stall_left = stall_n; fin = 0;
    @(negedge clk);
    start = 1'b1; valid = 1'b1; sdata = mk_word(0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (wen) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (wdata !== 8'(bidx + 1)) begin
          if (err_cnt == 0) begin err_act = int'(wdata); err_exp = (bidx + 1) & 255; end
          err_cnt++;
        end
        bidx++;
        en_cnt++;
        if (bidx == 30720) ready_last = int'(ready);
      end else if (wdata !== 8'h00) begin
        if (err_cnt == 0) begin err_act = int'(wdata); err_exp = 0; end
        err_cnt++;
      end
      if (cyc == 1) busy_fetch = int'(busy);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          busy_done = int'(busy);
`ifdef F5_WSTREAM_CKSUM_EN
          ck_at_done = cksum;
`endif
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        done_after  = int'(done);
        ready_after = int'(ready);
        fin = 1;
      end
      if (!fin && abort_at >= 0 && bidx == abort_at) begin
        rstn = 1'b0;
        @(negedge clk);
        post_en = int'(wen); post_busy = int'(busy); post_ready = int'(ready);
        rstn = 1'b1;
        aborted = 1;
        fin = 1;
      end
      if (cyc > 40000) begin timeout = 1; fin = 1; end
      if (!fin) begin
        if (cyc == start_at) start = 1'b1;
        if (ready && stall_left > 0 && words == 2) begin
          valid = 1'b0;
          stall_left--;
        end else begin
          valid = 1'b1;
        end
        sdata = mk_word(words);
        if (ready && valid) words++;
      end
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic run_small(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] ws [3];
    int bidx;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    words = 0; bidx = 0; done_cyc = -1; done_cnt = 0; ck_at_done = '0;
    for (int i = 0; i < 8; i++) s_bytes[i] = 8'h00;
    @(negedge clk);
    s_start = 1'b1; s_valid = 1'b1; s_sdata = ws[0];
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_wen) begin
        if (bidx < 8) s_bytes[bidx] = s_wdata;
        bidx++;
      end
      if (s_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
`ifdef F5_WSTREAM_CKSUM_EN
        ck_at_done = s_cksum;
`endif
      end
      s_sdata = ws[(words > 2) ? 2 : words];
      if (s_ready) words++;
    end
    en_cnt = bidx;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; valid = 1'b1; sdata = 32'h04030201;
    s_start = 1'b0; s_valid = 1'b1; s_sdata = 32'h04030201;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ready, wen, wdata, busy, done} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 000", i, {ready, wen, wdata, busy, done});
      end
      total++;
      if ({s_ready, s_wen, s_wdata, s_busy, s_done} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs_small cycle %0d: got %h expected 000", i, {s_ready, s_wen, s_wdata, s_busy, s_done});
      end
    end
`ifdef F5_WSTREAM_CKSUM_EN
    total++;
    if (cksum !== 16'h0000) begin bad++; $display("FAIL reset_cksum: got %h expected 0000", cksum); end
`endif
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({ready, busy, wen} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: ready/busy/en got %b expected 000", {ready, busy, wen});
    end
    valid = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_full_load();
    run_load(0, -1, -1);
    total++; if (timeout !== 0) begin bad++; $display("FAIL full_timeout: done not seen within bound"); end
    total++; if (en_cnt !== 30720) begin bad++; $display("FAIL full_en_count: got %0d expected 30720", en_cnt); end
    total++; if (words !== 7680) begin bad++; $display("FAIL full_words: got %0d expected 7680", words); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL full_byte_order: %0d errors, first got %h expected %h", err_cnt, err_act, err_exp); end
    total++; if (first_en !== 2) begin bad++; $display("FAIL full_first_byte_cycle: got %0d expected 2", first_en); end
    total++; if (last_en - first_en + 1 !== 30720) begin bad++; $display("FAIL full_no_bubble: span got %0d expected 30720", last_en - first_en + 1); end
    total++; if (busy_fetch !== 1) begin bad++; $display("FAIL full_busy_fetch: got %0d expected 1", busy_fetch); end
    total++; if (ready_last !== 0) begin bad++; $display("FAIL full_ready_final_byte: got %0d expected 0", ready_last); end
    total++; if (done_cyc !== last_en + 1) begin bad++; $display("FAIL full_done_timing: got %0d expected %0d", done_cyc, last_en + 1); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
    total++; if (busy_done !== 0) begin bad++; $display("FAIL full_busy_at_done: got %0d expected 0", busy_done); end
    total++; if ({done_after, ready_after} !== {32'd0, 32'd0}) begin bad++; $display("FAIL full_idle_after_done: done %0d ready %0d expected 0 0", done_after, ready_after); end
`ifdef F5_WSTREAM_CKSUM_EN
    total++; if (ck_at_done !== 16'hC400) begin bad++; $display("FAIL full_cksum: got %h expected c400", ck_at_done); end
`endif
  endtask

  task automatic test_stall();
    run_load(3, -1, -1);
    total++; if (timeout !== 0) begin bad++; $display("FAIL stall_timeout: done not seen within bound"); end
    total++; if (en_cnt !== 30720) begin bad++; $display("FAIL stall_en_count: got %0d expected 30720", en_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL stall_byte_order: %0d errors, first got %h expected %h", err_cnt, err_act, err_exp); end
    total++; if (last_en - first_en + 1 !== 30723) begin bad++; $display("FAIL stall_gap: span got %0d expected 30723", last_en - first_en + 1); end
    total++; if (words !== 7680) begin bad++; $display("FAIL stall_words: got %0d expected 7680", words); end
  endtask

  task automatic test_control();
    run_load(0, 100, 1000);
    total++; if (aborted !== 1) begin bad++; $display("FAIL ctrl_reached_1000: aborted %0d expected 1", aborted); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL ctrl_start_ignored_order: %0d errors, first got %h expected %h", err_cnt, err_act, err_exp); end
    total++; if (last_en - first_en + 1 !== 1000) begin bad++; $display("FAIL ctrl_start_ignored_span: got %0d expected 1000", last_en - first_en + 1); end
    total++; if ({post_en, post_busy, post_ready} !== {32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL ctrl_reset_idle: en %0d busy %0d ready %0d expected 0 0 0", post_en, post_busy, post_ready);
    end
    run_load(0, -1, 8);
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL ctrl_restart_order: first got %h expected %h", err_act, err_exp); end
    total++; if (first_en !== 2) begin bad++; $display("FAIL ctrl_restart_first: got %0d expected 2", first_en); end
  endtask

  task automatic test_partial();
    logic [7:0] exp_b [6];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
    run_small(32'h44332211, 32'h88776655, 32'hCCBBAA99);
    total++; if (words !== 2) begin bad++; $display("FAIL partial_words: got %0d expected 2", words); end
    total++; if (en_cnt !== 6) begin bad++; $display("FAIL partial_bytes: got %0d expected 6", en_cnt); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (s_bytes[i] !== exp_b[i]) begin bad++; $display("FAIL partial_byte%0d: got %h expected %h", i, s_bytes[i], exp_b[i]); end
    end
    total++; if (done_cyc !== 8) begin bad++; $display("FAIL partial_done_cycle: got %0d expected 8", done_cyc); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL partial_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_cksum();
`ifdef F5_WSTREAM_CKSUM_EN
    run_small(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total++; if (ck_at_done !== 16'h05FA) begin bad++; $display("FAIL cksum_small: got %h expected 05fa", ck_at_done); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_control();
    test_partial();
    test_cksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
